// File: rtl/latch_bank_dbuf.sv
// latch_bank_dbuf: CHANNELS x WIDTH data latch bank with a shadow bank,
// a bank-wide commit strobe and a per-write transparent mode.
// Optional feature macro: LATCH_BANK_PARITY_EN adds q_par (even parity per
// channel, registered alongside q).
module latch_bank_dbuf #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned SEL_W    = 2,
  parameter int unsigned CNT_W    = 8
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         wr_en,
  input  logic [SEL_W-1:0]             wr_sel,
  input  logic [WIDTH-1:0]             wr_data,
  input  logic                         commit,
  input  logic                         transparent,
  output logic [CHANNELS*WIDTH-1:0]    q,
  output logic [CHANNELS*WIDTH-1:0]    qb,
  output logic [CHANNELS-1:0]          dirty,
  output logic [CNT_W-1:0]             commit_cnt,
  output logic                         wr_err
`ifdef LATCH_BANK_PARITY_EN
  ,
  output logic [CHANNELS-1:0]          q_par
`endif
);

  localparam logic [SEL_W:0] CH_LIM = (SEL_W+1)'(CHANNELS);

  logic [CHANNELS-1:0][WIDTH-1:0] shadow_r, shadow_nxt;
  logic [CHANNELS-1:0][WIDTH-1:0] q_r, q_nxt;
  logic [CHANNELS-1:0]            dirty_r, dirty_nxt;
  logic [CNT_W-1:0]               cnt_r;
  logic                           err_r;
  logic                           sel_ok;
  logic [CHANNELS-1:0]            wr_hit;

  assign sel_ok = ({1'b0, wr_sel} < CH_LIM);

  // One-hot decode of a valid write target; out-of-range selects hit nothing.
  always_comb begin
    wr_hit = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (wr_en && sel_ok && (wr_sel == SEL_W'(k)))
        wr_hit[k] = 1'b1;
    end
  end

  // Next-state for shadow, output bank and dirty flags.
  // A commit copies the post-write shadow, so a same-edge write bypasses into q.
  always_comb begin
    shadow_nxt = shadow_r;
    q_nxt      = q_r;
    dirty_nxt  = dirty_r;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (wr_hit[k])
        shadow_nxt[k] = wr_data;
      if (commit) begin
        q_nxt[k]     = shadow_nxt[k];
        dirty_nxt[k] = 1'b0;
      end else if (wr_hit[k]) begin
        if (transparent) begin
          q_nxt[k]     = wr_data;
          dirty_nxt[k] = 1'b0;
        end else begin
          dirty_nxt[k] = 1'b1;
        end
      end
    end
  end

  // State registers; reset dominates any same-cycle write or commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      shadow_r <= '0;
      q_r      <= '0;
      dirty_r  <= '0;
      cnt_r    <= '0;
      err_r    <= 1'b0;
    end else begin
      shadow_r <= shadow_nxt;
      q_r      <= q_nxt;
      dirty_r  <= dirty_nxt;
      if (commit)
        cnt_r <= cnt_r + 1'b1;
      err_r <= wr_en && !sel_ok;
    end
  end

`ifdef LATCH_BANK_PARITY_EN
  logic [CHANNELS-1:0] par_r, par_nxt;

  // Parity computed from the next output bank so it updates with q.
  always_comb begin
    par_nxt = '0;
    for (int unsigned k = 0; k < CHANNELS; k++)
      par_nxt[k] = ^q_nxt[k];
  end

  // Parity register, same reset and timing as q.
  always_ff @(posedge clk) begin
    if (!rst_n)
      par_r <= '0;
    else
      par_r <= par_nxt;
  end

  assign q_par = par_r;
`endif

  assign q          = q_r;
  assign qb         = ~q_r;
  assign dirty      = dirty_r;
  assign commit_cnt = cnt_r;
  assign wr_err     = err_r;

endmodule
